// File: rtl/jpeg_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_pkg
// Shared definitions for the JPEG bit packer: FSM state encoding and the
// JPEG marker / stuffing byte constants.
// Build option: JPEG_PACK_MARKER_EN adds the SOI/EOI marker states.
// -----------------------------------------------------------------------------
package jpeg_pkg;

  localparam logic [7:0] JPEG_MARK_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_SOI         = 8'hD8;
  localparam logic [7:0] JPEG_EOI         = 8'hD9;
  localparam logic [7:0] JPEG_STUFF       = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PACK   = 4'd1,
    ST_STUFF  = 4'd2,
    ST_FLUSH  = 4'd3,
    ST_DONE   = 4'd4
`ifdef JPEG_PACK_MARKER_EN
    ,
    ST_SOI_FF = 4'd5,
    ST_SOI_D8 = 4'd6,
    ST_EOI_FF = 4'd7,
    ST_EOI_D9 = 4'd8
`endif
  } pack_state_t;

endpackage

// File: rtl/jpeg_code_fifo.sv
// -----------------------------------------------------------------------------
// jpeg_code_fifo
// Synchronous FIFO holding {code, length, eof} entries for the bit packer.
// A write into a full FIFO is dropped and flagged on wr_drop; fullness comes
// from the registered count, so a pop in the same cycle does not make room.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   wr_en, wr_data   write strobe and entry
//   rd_en            pop the head entry (ignored when empty)
//   rd_data          head entry (valid when ~empty)
//   empty, full      occupancy flags
//   wr_drop          write attempted while full (this cycle)
// -----------------------------------------------------------------------------
module jpeg_code_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_ok, rd_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign wr_drop = wr_en & full;
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jpeg_bit_packer.sv
// -----------------------------------------------------------------------------
// jpeg_bit_packer
// Packs right-aligned variable-length Huffman codes MSB-first into bytes,
// inserts 0x00 after every 0xFF data byte, pads the last byte of a frame with
// 1s and streams bytes out over valid/ready.
// Build option: JPEG_PACK_MARKER_EN wraps each frame in SOI (FF D8) and
// EOI (FF D9) markers; frame_done then follows the accepted D9.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   din, din_len, din_eof       code, bit count (0..CODE_W, larger clamps), eof
//   din_valid                   entry strobe, no backpressure
//   dout, dout_valid, dout_ready  registered byte stream
//   frame_done                  one-cycle pulse after last frame byte accepted
//   overflow                    sticky, an entry was dropped (FIFO full)
//   busy                        FIFO, accumulator or FSM still active
// -----------------------------------------------------------------------------
module jpeg_bit_packer
  import jpeg_pkg::*;
#(
  parameter int CODE_W     = 32,
  parameter int LEN_W      = 6,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] din,
  input  logic [LEN_W-1:0]  din_len,
  input  logic              din_eof,
  input  logic              din_valid,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int ACC_W = CODE_W + 7;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int FW    = CODE_W + LEN_W + 1;

  // ---------------------------------------------------------------- input FIFO
  logic [LEN_W-1:0]  wr_len;
  logic [FW-1:0]     rd_data;
  logic              fifo_empty, fifo_full, wr_drop, pop;
  logic [CODE_W-1:0] pop_code;
  logic [LEN_W-1:0]  pop_len;
  logic              pop_eof;

  assign wr_len = (din_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : din_len;

  jpeg_code_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (din_valid),
    .wr_data ({din, wr_len, din_eof}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .wr_drop (wr_drop)
  );

  assign pop_code = rd_data[FW-1 -: CODE_W];
  assign pop_len  = rd_data[LEN_W:1];
  assign pop_eof  = rd_data[0];

  // -------------------------------------------------------------- state
  pack_state_t      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eof_pend_q, eof_pend_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q;

  // ------------------------------------------------------ datapath helpers
  logic [CODE_W-1:0] code_mask, code_m;
  logic [ACC_W-1:0]  code_ext, pop_bits;
  logic [7:0]        top_byte, pad_byte;
  logic              out_free;

  // Code sits right-aligned in the top CODE_W bits of code_ext; shifting left
  // by (CODE_W - len) brings its MSB to the accumulator MSB, then shifting
  // right by cnt_q places it directly below the bits already held.
  assign code_mask = ~({CODE_W{1'b1}} << pop_len);
  assign code_m    = pop_code & code_mask;
  assign code_ext  = {code_m, 7'b0};
  assign pop_bits  = (code_ext << (LEN_W'(CODE_W) - pop_len)) >> cnt_q;

  assign top_byte  = acc_q[ACC_W-1 -: 8];
  // Only used when fewer than 8 bits remain: fill the unused tail with 1s.
  assign pad_byte  = top_byte | (8'hFF >> cnt_q[2:0]);
  assign out_free  = ~dout_valid_q | dout_ready;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    eof_pend_d   = eof_pend_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q & ~dout_ready;
    frame_done_d = 1'b0;
    pop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
`ifdef JPEG_PACK_MARKER_EN
          state_d = ST_SOI_FF;
`else
          // Popping on the way out of IDLE keeps write-to-byte latency at 3.
          pop     = 1'b1;
          state_d = ST_PACK;
`endif
        end
      end

      ST_PACK: begin
        if (cnt_q >= CNT_W'(8)) begin
          if (out_free) begin
            dout_d       = top_byte;
            dout_valid_d = 1'b1;
            acc_d        = acc_q << 8;
            cnt_d        = cnt_q - CNT_W'(8);
            if (top_byte == JPEG_MARK_PREFIX) state_d = ST_STUFF;
          end
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end else if (eof_pend_q) begin
          state_d = ST_FLUSH;
        end
      end

      ST_STUFF: begin
        if (out_free) begin
          dout_d       = JPEG_STUFF;
          dout_valid_d = 1'b1;
          state_d      = ST_PACK;
        end
      end

      ST_FLUSH: begin
        if (cnt_q != '0) begin
          if (out_free) begin
            dout_d       = pad_byte;
            dout_valid_d = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
            // eof_pend stays set so PACK comes back here after the stuff byte.
            if (pad_byte == JPEG_MARK_PREFIX) state_d = ST_STUFF;
          end
        end else begin
`ifdef JPEG_PACK_MARKER_EN
          state_d = ST_EOI_FF;
`else
          state_d = ST_DONE;
`endif
        end
      end

`ifdef JPEG_PACK_MARKER_EN
      ST_SOI_FF: begin
        if (out_free) begin
          dout_d       = JPEG_MARK_PREFIX;
          dout_valid_d = 1'b1;
          state_d      = ST_SOI_D8;
        end
      end

      ST_SOI_D8: begin
        if (out_free) begin
          dout_d       = JPEG_SOI;
          dout_valid_d = 1'b1;
          state_d      = ST_PACK;
        end
      end

      ST_EOI_FF: begin
        if (out_free) begin
          dout_d       = JPEG_MARK_PREFIX;
          dout_valid_d = 1'b1;
          state_d      = ST_EOI_D9;
        end
      end

      ST_EOI_D9: begin
        if (out_free) begin
          dout_d       = JPEG_EOI;
          dout_valid_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        // out_free here means the final byte is gone or leaves this edge.
        if (out_free) begin
          frame_done_d = 1'b1;
          eof_pend_d   = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Pops happen only with cnt_q < 8, so the appended code always fits.
    if (pop) begin
      acc_d = acc_q | pop_bits;
      cnt_d = cnt_q + CNT_W'(pop_len);
      if (pop_eof) eof_pend_d = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      eof_pend_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      eof_pend_q   <= eof_pend_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_q | wr_drop;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = ~fifo_empty | (cnt_q != '0) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// -----------------------------------------------------------------------------
// tb_jpeg_bit_packer
// Directed stimulus with hand-computed byte streams pushed into a scoreboard
// queue; a negedge monitor pops and compares every accepted byte and checks
// that a stalled byte is the expected head. Build with JPEG_PACK_MARKER_EN to
// expect SOI/EOI markers around each frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jpeg_bit_packer;

  localparam int CODE_W     = 32;
  localparam int LEN_W      = 6;
  localparam int FIFO_DEPTH = 16;
`ifdef JPEG_PACK_MARKER_EN
  localparam int KEPT = 14;  // two entries already queued behind SOI
`else
  localparam int KEPT = 16;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CODE_W-1:0] din = '0;
  logic [LEN_W-1:0]  din_len = '0;
  logic              din_eof = 1'b0;
  logic              din_valid = 1'b0;
  logic [7:0]        dout;
  logic              dout_valid;
  logic              dout_ready = 1'b1;
  logic              frame_done;
  logic              overflow;
  logic              busy;

  always #5 clk = ~clk;

  jpeg_bit_packer #(
    .CODE_W(CODE_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_len    (din_len),
    .din_eof    (din_eof),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  int         errors = 0;
  int         checks = 0;
  int         accepted = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (dout_valid && dout_ready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got 0x%0h expected no byte", dout);
        end else begin
          check("byte", {24'h0, dout}, {24'h0, exp_q.pop_front()});
        end
      end else if (dout_valid && exp_q.size() > 0) begin
        check("stall_hold", {24'h0, dout}, {24'h0, exp_q[0]});
      end
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [CODE_W-1:0] c, input logic [LEN_W-1:0] l, input logic e);
    din       = c;
    din_len   = l;
    din_eof   = e;
    din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
  endtask

  task automatic exp_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic exp_soi();
`ifdef JPEG_PACK_MARKER_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD8);
`endif
  endtask

  task automatic exp_eoi();
`ifdef JPEG_PACK_MARKER_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
`endif
  endtask

  task automatic wait_frame(input string name, input int want_done);
    for (int i = 0; i < 400 && done_cnt < want_done; i++) tick(1);
    tick(3);
    check({name, "_done"}, done_cnt, want_done);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int lat;
    int base;

    tick(3);
    check("reset_outputs", {23'h0, dout, dout_valid, frame_done, overflow, busy}, 32'h0);
    rst = 1'b0;
    tick(2);

    // Frame 1: one 32-bit code with eof; also measures write-to-byte latency.
    exp_soi();
    exp_byte(8'h12); exp_byte(8'h34); exp_byte(8'h56); exp_byte(8'h78);
    exp_eoi();
    din = 32'h1234_5678; din_len = 6'd32; din_eof = 1'b1; din_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      lat++;
    end while (!dout_valid && lat < 10);
    check("latency", lat, 3);
    wait_frame("f1_32bit", 1);
    check("idle_not_busy", {31'h0, busy}, 32'h0);

    // Frame 2: 101 + 11111 -> 0xBF, then an empty eof entry closes it.
    exp_soi();
    exp_byte(8'hBF);
    exp_eoi();
    send(32'h5, 6'd3, 1'b0);
    send(32'h1F, 6'd5, 1'b0);
    tick(4);
    send(32'h0, 6'd0, 1'b1);
    wait_frame("f2_bf", 2);

    // Frame 3: 0xFF data byte is stuffed; 1-bit code padded to 0xFF, stuffed.
    exp_soi();
    exp_byte(8'hFF); exp_byte(8'h00); exp_byte(8'hFF); exp_byte(8'h00);
    exp_eoi();
    send(32'hFF, 6'd8, 1'b0);
    send(32'h1, 6'd1, 1'b1);
    wait_frame("f3_stuff", 3);

    // Frame 4: length above CODE_W clamps to 32; upper din bits ignored.
    exp_soi();
    exp_byte(8'h01); exp_byte(8'h02); exp_byte(8'h03); exp_byte(8'h04);
    exp_eoi();
    send(32'h0102_0304, 6'd63, 1'b1);
    wait_frame("f4_clamp", 4);

    // Frame 5: sink stalled for 30+ cycles; pipeline saturates, then 17 more
    // codes overrun the FIFO.
    dout_ready = 1'b0;
    exp_soi();
    exp_byte(8'h11); exp_byte(8'h22);
    send(32'h11, 6'd8, 1'b0);
    send(32'h22, 6'd8, 1'b0);
    tick(10);
    for (int i = 0; i < 17; i++) begin
      if (i < KEPT) exp_byte(8'h40 + 8'(i));
      send(32'h40 + 32'(i), 6'd8, 1'b0);
    end
    @(negedge clk);
    check("overflow_set", {31'h0, overflow}, 32'h1);
    check("busy_stalled", {31'h0, busy}, 32'h1);
    tick(4);
    dout_ready = 1'b1;
    tick(6);
    exp_eoi();
    send(32'h0, 6'd0, 1'b1);
    wait_frame("f5_overflow", 5);

    // Frame 6: empty eof entry with empty accumulator -> markers only.
    exp_soi();
    exp_eoi();
    send(32'h0, 6'd0, 1'b1);
    wait_frame("f6_empty", 6);
    check("overflow_sticky", {31'h0, overflow}, 32'h1);
    check("empty_not_busy", {31'h0, busy}, 32'h0);

    // Mid-frame reset after two accepted bytes.
    exp_soi();
    exp_byte(8'h12); exp_byte(8'h34); exp_byte(8'h56); exp_byte(8'h78);
    exp_eoi();
    base = accepted;
    send(32'h1234_5678, 6'd32, 1'b1);
    for (int i = 0; i < 100 && accepted < base + 2; i++) tick(1);
    check("reset_wait_bytes", {31'h0, accepted >= base + 2}, 32'h1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midframe_reset_outputs", {23'h0, dout, dout_valid, frame_done, overflow, busy}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    // Frame 7: 1010 padded with 1111 -> 0xAF.
    exp_soi();
    exp_byte(8'hAF);
    exp_eoi();
    send(32'hA, 6'd4, 1'b1);
    wait_frame("f7_after_reset", 7);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a wait above misbehaves.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/jpeg_bit_packer.md
Name: jpeg_bit_packer

Overview:
- Sits between the JPEG entropy encoder and the UART TX streamer.
- Accepts variable-length Huffman codes from the encoder (no backpressure) into an internal FIFO, then packs them MSB-first into bytes.
- Applies JPEG 0xFF byte stuffing, pads the final byte with 1s at end of frame, and drives a valid/ready byte stream towards the UART.
- Replaces fixed 32-bit word transfer with a generalised code width, FIFO depth and frame-aware flushing.

Parameters:
- CODE_W, 32, maximum code length in bits; input code is right-aligned.
- LEN_W, 6, width of length field; must satisfy 2**LEN_W > CODE_W.
- FIFO_DEPTH, 16, input FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- din  in  CODE_W  code bits, right-aligned, upper bits ignored
- din_len  in  LEN_W  number of valid code bits, 0..CODE_W
- din_eof  in  1  last code of frame; triggers pad/flush after this code
- din_valid  in  1  entry strobe; no ready returned
- dout  out  8  packed byte
- dout_valid  out  1  byte available
- dout_ready  in  1  sink accepts byte (UART ~tx_full)
- frame_done  out  1  one-cycle pulse after last byte of frame accepted
- overflow  out  1  sticky: an entry was dropped
- busy  out  1  FIFO non-empty or accumulator non-empty or FSM not IDLE

Behaviour:
- Reset, asynchronous on rst high: all outputs 0; FIFO empty; acc_cnt 0; FSM IDLE. A mid-frame reset discards all state; no partial flush.
- FIFO write:
  - din_valid with FIFO not full writes {din, din_len, din_eof}.
  - din_valid with FIFO full drops the entry and sets overflow; overflow clears only on rst.
  - din_len > CODE_W is treated as CODE_W.
- Accumulator:
  - ACC_W = CODE_W+7 bits; acc_cnt counts valid bits, left-justified.
  - A pop appends din_len bits below the existing bits.
- Output register:
  - dout/dout_valid are registered and held stable while dout_valid & ~dout_ready.
  - The register is free when ~dout_valid | dout_ready.
- FSM (one action per cycle, priority top-down):
  - IDLE: if FIFO non-empty, go to PACK. With JPEG_PACK_MARKER_EN, go to SOI_FF first when starting a new frame.
  - PACK:
    - If acc_cnt >= 8 and the register is free, emit the top byte and decrement acc_cnt by 8. If that byte is 0xFF, go to STUFF.
    - Else if acc_cnt < 8 and FIFO non-empty, pop one entry. If its eof is set, latch eof_pend.
    - Else if eof_pend and acc_cnt < 8, go to FLUSH.
  - STUFF: when the register is free, emit 0x00, then return to PACK.
  - FLUSH:
    - If acc_cnt > 0, pad to 8 bits with 1s and emit; 0xFF goes to STUFF with eof_pend kept.
    - If acc_cnt == 0, go to EOI_FF (marker build) or DONE.
  - SOI_FF/SOI_D8 and EOI_FF/EOI_D9: emit 0xFF then 0xD8 (or 0xD9). Markers are never stuffed.
  - DONE: wait for the last byte to be accepted, pulse frame_done, clear eof_pend, go to IDLE.
- Latency: from a din_valid write into an empty, idle block (no markers) with dout_ready high, a code of 8 or more bits yields dout_valid 3 cycles later (write, pop, emit).
- Simultaneous write and pop on a full FIFO: the pop frees space only from the next cycle, so the write is dropped and overflow is set.
- A din_len == 0 entry with eof set is legal and is a pure flush.
- Throughput: at most one byte per cycle.

Optional Feature:
- JPEG_PACK_MARKER_EN defined: emits SOI (0xFF 0xD8) before the first byte of each frame and EOI (0xFF 0xD9) after the padded final byte. frame_done fires after 0xD9 is accepted.
- Undefined: SOI/EOI states are not built; the stream is raw stuffed scan data only. frame_done fires after the last padded/stuffed byte.

Decomposition:
- Package jpeg_pkg holds:
  - typedef pack_state_t for the FSM states;
  - constants JPEG_MARK_PREFIX=8'hFF, JPEG_SOI=8'hD8, JPEG_EOI=8'hD9, JPEG_STUFF=8'h00.
- Sub-module jpeg_code_fifo: synchronous FIFO parametrised by width and depth, with full/empty and an overflow-safe write.

Test Plan:
- Codes (0b101, len 3) then (0b11111, len 5), no eof -> single byte 0xBF.
- Code 0xFF len 8 then (0x1, len 1, eof) -> bytes 0xFF, 0x00, 0xFF, 0x00. Marker build: 0xFF 0xD8 prefix and 0xFF 0xD9 suffix.
- Hold dout_ready low for 20 cycles mid-frame -> dout stable and no byte lost. Write 17 codes with FIFO_DEPTH=16 -> overflow=1, then remains 1.
- Code 0x12345678 len 32 with eof -> 0x12 0x34 0x56 0x78, no pad byte, frame_done pulses once.
- Assert rst mid-frame after 2 bytes -> all outputs 0 next cycle. A new frame (0xA, len 4, eof) -> 0xAF.
- Empty eof entry (len 0) with acc_cnt 0 -> no data byte; only frame_done, preceded by markers if built.
